l1_dcache_ctrl: RTL and testbench

//  Direct-mapped, write-back, write-allocate L1 data cache controller; one per core.

---
 rtl/l1_dcache_ctrl_if.sv | 30 +++
 rtl/l1_dcache_ctrl.sv | 174 +++++++++++++++++
 tb/tb_l1_dcache_ctrl.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/l1_dcache_ctrl_if.sv
// Core-side request/response and shared-memory handshake signals of one L1 data cache.
// The master side is the core plus memory; the slave side is the cache controller.
interface l1_dcache_ctrl_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
);
    logic              cpu_read;
    logic              cpu_write;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] fetched_data;
    logic              stall_cpu;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output cpu_read, cpu_write, cpu_addr, cpu_wdata, mem_ready, mem_rdata,
        input  fetched_data, stall_cpu, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  cpu_read, cpu_write, cpu_addr, cpu_wdata, mem_ready, mem_rdata,
        output fetched_data, stall_cpu, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/l1_dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate L1 data cache controller, one word per line.
// Hits complete in IDLE without stalling; misses run WB (if dirty) then FILL over a req/ready port.
module l1_dcache_ctrl #(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 32,
    parameter int INDEX_W = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             resetn,
    l1_dcache_ctrl_if.slave  bus,
    output logic [CNT_W-1:0] hit_count_o,
    output logic [CNT_W-1:0] miss_count_o
);
    localparam int TAG_W = ADDR_W - INDEX_W;
    localparam int LINES = 1 << INDEX_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WB   = 2'd1,
        S_FILL = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [LINES-1:0]  valid_q;
    logic [LINES-1:0]  dirty_q;
    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [DATA_W-1:0] data_mem [LINES];

    logic [DATA_W-1:0] fetched_q, fetched_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;

    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tag;
    logic               req;
    logic               hit;
    logic               fill_we;
    logic               hit_we;

    assign idx = bus.cpu_addr[INDEX_W-1:0];
    assign tag = bus.cpu_addr[ADDR_W-1:INDEX_W];
    assign req = bus.cpu_read | bus.cpu_write;
    assign hit = valid_q[idx] & (tag_mem[idx] == tag);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    // Write wins when both request lines are set, so only cpu_write selects the write path.
    always_comb begin
        state_d     = state_q;
        fetched_d   = fetched_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        fill_we     = 1'b0;
        hit_we      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (hit) begin
                        hit_cnt_d = sat_inc(hit_cnt_q);
                        if (bus.cpu_write) begin
                            hit_we = 1'b1;
                        end else begin
                            fetched_d = data_mem[idx];
                        end
                    end else begin
                        miss_cnt_d = sat_inc(miss_cnt_q);
                        mem_req_d  = 1'b1;
                        if (valid_q[idx] && dirty_q[idx]) begin
                            state_d     = S_WB;
                            mem_we_d    = 1'b1;
                            mem_addr_d  = {tag_mem[idx], idx};
                            mem_wdata_d = data_mem[idx];
                        end else begin
                            state_d    = S_FILL;
                            mem_we_d   = 1'b0;
                            mem_addr_d = bus.cpu_addr;
                        end
                    end
                end
            end
            S_WB: begin
                if (bus.mem_ready) begin
                    state_d    = S_FILL;
                    mem_we_d   = 1'b0;
                    mem_addr_d = bus.cpu_addr;
                end
            end
            S_FILL: begin
                if (bus.mem_ready) begin
                    fill_we   = 1'b1;
                    mem_req_d = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            fetched_q   <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            fetched_q   <= fetched_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

    // Tag/data storage is never cleared; only the valid bits make a line meaningful.
    always_ff @(posedge clk) begin
        if (resetn) begin
            if (fill_we) begin
                data_mem[idx] <= bus.mem_rdata;
                tag_mem[idx]  <= tag;
            end else if (hit_we) begin
                data_mem[idx] <= bus.cpu_wdata;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < LINES; gi++) begin : g_line
            always_ff @(posedge clk) begin
                if (!resetn) begin
                    valid_q[gi] <= 1'b0;
                    dirty_q[gi] <= 1'b0;
                end else if (idx == INDEX_W'(gi)) begin
                    if (fill_we) begin
                        valid_q[gi] <= 1'b1;
                        dirty_q[gi] <= 1'b0;
                    end else if (hit_we) begin
                        dirty_q[gi] <= 1'b1;
                    end
                end
            end
        end
    endgenerate

    assign bus.fetched_data = fetched_q;
    assign bus.stall_cpu    = resetn & ((state_q != S_IDLE) | (req & ~hit));
    assign bus.mem_req      = mem_req_q;
    assign bus.mem_we       = mem_we_q;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_wdata    = mem_wdata_q;
    assign hit_count_o      = hit_cnt_q;
    assign miss_count_o     = miss_cnt_q;
endmodule

// File: tb/tb_l1_dcache_ctrl.sv
// Bench for l1_dcache_ctrl: directed scenarios then random traffic, checked against a
// word-level memory view plus a line-ownership model of the direct-mapped cache.
module tb_l1_dcache_ctrl;
    localparam int ADDR_W  = 9;
    localparam int DATA_W  = 32;
    localparam int INDEX_W = 4;
    localparam int CNT_W   = 6;
    localparam int LINES   = 1 << INDEX_W;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic [CNT_W-1:0] hit_count;
    logic [CNT_W-1:0] miss_count;

    l1_dcache_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_if ();

    l1_dcache_ctrl #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .INDEX_W(INDEX_W),
        .CNT_W  (CNT_W)
    ) u_dut (
        .clk         (clk),
        .resetn      (resetn),
        .bus         (bus_if.slave),
        .hit_count_o (hit_count),
        .miss_count_o(miss_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } txn_t;

    // Environment memory, and the value the core must observe at every address.
    logic [DATA_W-1:0] backing [1 << ADDR_W];
    logic [DATA_W-1:0] golden  [1 << ADDR_W];

    // Which address each line holds, and whether it is newer than memory.
    bit                m_valid [LINES];
    bit                m_dirty [LINES];
    logic [ADDR_W-1:0] m_addr  [LINES];
    int                exp_hits;
    int                exp_misses;
    logic [DATA_W-1:0] exp_fetched;

    txn_t log_q[$];
    int   req_cycles;
    int   lat_sel = 3;
    bit   spur_en = 1'b0;

    // Memory responder: logs each transaction, keeps its outputs under watch, answers after a latency.
    initial begin : responder
        bit   busy;
        int   cnt;
        txn_t cur;
        busy = 1'b0;
        cnt  = 0;
        cur  = '0;
        bus_if.mem_ready = 1'b0;
        bus_if.mem_rdata = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!resetn) begin
                busy = 1'b0;
                bus_if.mem_ready = 1'b0;
            end else begin
                if (bus_if.mem_ready) begin
                    bus_if.mem_ready = 1'b0;
                    busy = 1'b0;
                end
                if (bus_if.mem_req) req_cycles++;
                if (busy) begin
                    check_val("mem_hold_we", bus_if.mem_we, cur.we);
                    check_val("mem_hold_addr", bus_if.mem_addr, cur.addr);
                    if (cur.we) check_val("mem_hold_wdata", bus_if.mem_wdata, cur.wdata);
                    cnt--;
                end else if (bus_if.mem_req) begin
                    cur.we    = bus_if.mem_we;
                    cur.addr  = bus_if.mem_addr;
                    cur.wdata = bus_if.mem_we ? bus_if.mem_wdata : '0;
                    log_q.push_back(cur);
                    busy = 1'b1;
                    cnt  = (lat_sel >= 0) ? lat_sel : int'($urandom_range(0, 4));
                end else if (spur_en && $urandom_range(0, 7) == 0) begin
                    bus_if.mem_ready = 1'b1;
                    bus_if.mem_rdata = $urandom;
                end
                if (busy && cnt == 0) begin
                    bus_if.mem_ready = 1'b1;
                    if (cur.we) begin
                        backing[cur.addr] = cur.wdata;
                        bus_if.mem_rdata  = $urandom;
                    end else begin
                        bus_if.mem_rdata = backing[cur.addr];
                    end
                end
            end
        end
    end

    function automatic int sat(input int v);
        return (v > CNT_MAX) ? CNT_MAX : v;
    endfunction

    task automatic do_access(input bit rd, input bit wr, input logic [ADDR_W-1:0] a,
                             input logic [DATA_W-1:0] wd, input string tag);
        int                 li;
        bit                 req;
        bit                 exp_hit;
        int                 stall_cycles;
        txn_t               exp_txn[$];
        txn_t               t;
        li      = int'(a[INDEX_W-1:0]);
        req     = rd | wr;
        exp_hit = m_valid[li] && (m_addr[li] == a);
        if (req && !exp_hit) begin
            if (m_valid[li] && m_dirty[li]) begin
                t.we = 1'b1; t.addr = m_addr[li]; t.wdata = golden[m_addr[li]];
                exp_txn.push_back(t);
            end
            t.we = 1'b0; t.addr = a; t.wdata = '0;
            exp_txn.push_back(t);
        end
        log_q.delete();
        req_cycles = 0;
        @(negedge clk);
        bus_if.cpu_read  = rd;
        bus_if.cpu_write = wr;
        bus_if.cpu_addr  = a;
        bus_if.cpu_wdata = wd;
        #1;
        stall_cycles = 0;
        while (bus_if.stall_cpu && stall_cycles < 40) begin
            stall_cycles++;
            @(negedge clk);
            #1;
        end
        check_val({tag, "_stall_end"}, bus_if.stall_cpu, 1'b0);
        check_val({tag, "_stalled"}, stall_cycles != 0, req && !exp_hit);
        @(negedge clk);
        #1;
        bus_if.cpu_read  = 1'b0;
        bus_if.cpu_write = 1'b0;

        if (req) begin
            if (!exp_hit) begin
                exp_misses++;
                m_valid[li] = 1'b1;
                m_dirty[li] = 1'b0;
                m_addr[li]  = a;
            end
            exp_hits++;
            if (wr) begin
                golden[a]   = wd;
                m_dirty[li] = 1'b1;
            end else begin
                exp_fetched = golden[a];
            end
        end
        $display("txn %s: rd=%0b wr=%0b addr=0x%03h hit=%0b stall=%0d fetched=0x%08h",
                 tag, rd, wr, a, exp_hit, stall_cycles, bus_if.fetched_data);
        check_val({tag, "_fetched"}, bus_if.fetched_data, exp_fetched);
        check_val({tag, "_hits"}, hit_count, sat(exp_hits));
        check_val({tag, "_misses"}, miss_count, sat(exp_misses));
        check_val({tag, "_ntxn"}, log_q.size(), exp_txn.size());
        if (!exp_hit && req) check_val({tag, "_stall_len"}, stall_cycles, 1 + req_cycles);
        for (int i = 0; i < exp_txn.size() && i < log_q.size(); i++) begin
            check_val({tag, "_txn_we"}, log_q[i].we, exp_txn[i].we);
            check_val({tag, "_txn_addr"}, log_q[i].addr, exp_txn[i].addr);
            if (exp_txn[i].we) check_val({tag, "_txn_wdata"}, log_q[i].wdata, exp_txn[i].wdata);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < LINES; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
            m_addr[i]  = '0;
        end
        for (int i = 0; i < (1 << ADDR_W); i++) golden[i] = backing[i];
        exp_hits    = 0;
        exp_misses  = 0;
        exp_fetched = '0;
    endtask

    // Reset asserted while a fill is outstanding: the transaction is abandoned at once.
    task automatic reset_during_fill(input logic [ADDR_W-1:0] a);
        bit found;
        int waited;
        log_q.delete();
        lat_sel = 8;
        @(negedge clk);
        bus_if.cpu_read  = 1'b1;
        bus_if.cpu_write = 1'b0;
        bus_if.cpu_addr  = a;
        found  = 1'b0;
        waited = 0;
        while (!found && waited < 40) begin
            @(negedge clk);
            #3;
            waited++;
            foreach (log_q[i]) if (!log_q[i].we && log_q[i].addr == a) found = 1'b1;
        end
        check_val("rst_fill_seen", found, 1'b1);
        check_val("rst_fill_req", bus_if.mem_req, 1'b1);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        check_val("rst_stall_forced", bus_if.stall_cpu, 1'b0);
        @(negedge clk);
        #1;
        check_val("rst_mem_req", bus_if.mem_req, 1'b0);
        check_val("rst_mem_we", bus_if.mem_we, 1'b0);
        check_val("rst_mem_addr", bus_if.mem_addr, '0);
        check_val("rst_fetched", bus_if.fetched_data, '0);
        check_val("rst_hits", hit_count, '0);
        check_val("rst_misses", miss_count, '0);
        check_val("rst_stall_hold", bus_if.stall_cpu, 1'b0);
        $display("txn reset_during_fill: addr=0x%03h", a);
        @(negedge clk);
        resetn = 1'b1;
        bus_if.cpu_read = 1'b0;
        model_reset();
        lat_sel = -1;
    endtask

    initial begin : main
        logic [ADDR_W-1:0] a;
        int                op;
        for (int i = 0; i < (1 << ADDR_W); i++) backing[i] = $urandom;
        backing[9'h005] = 32'hDEADBEEF;
        model_reset();

        bus_if.cpu_read  = 1'b1;
        bus_if.cpu_write = 1'b0;
        bus_if.cpu_addr  = 9'h005;
        bus_if.cpu_wdata = '0;
        repeat (3) @(negedge clk);
        #1;
        check_val("reset_stall", bus_if.stall_cpu, 1'b0);
        check_val("reset_mem_req", bus_if.mem_req, 1'b0);
        check_val("reset_mem_we", bus_if.mem_we, 1'b0);
        check_val("reset_mem_addr", bus_if.mem_addr, '0);
        check_val("reset_mem_wdata", bus_if.mem_wdata, '0);
        check_val("reset_fetched", bus_if.fetched_data, '0);
        check_val("reset_hits", hit_count, '0);
        check_val("reset_misses", miss_count, '0);
        @(negedge clk);
        resetn = 1'b1;
        bus_if.cpu_read = 1'b0;

        lat_sel = 3;
        do_access(1'b1, 1'b0, 9'h005, '0, "rd005_miss");
        lat_sel = -1;
        do_access(1'b0, 1'b1, 9'h005, 32'h12345678, "wr005_hit");
        do_access(1'b1, 1'b0, 9'h005, '0, "rd005_hit");
        do_access(1'b1, 1'b0, 9'h015, '0, "rd015_evict");
        do_access(1'b0, 1'b1, 9'h030, 32'hA5A55A5A, "wr030_miss");
        do_access(1'b1, 1'b0, 9'h040, '0, "rd040_evict");
        do_access(1'b1, 1'b1, 9'h005, 32'hCAFEF00D, "both005");
        do_access(1'b1, 1'b0, 9'h005, '0, "rd005_after_both");
        do_access(1'b0, 1'b0, 9'h005, '0, "noop");
        reset_during_fill(9'h015);
        do_access(1'b1, 1'b0, 9'h015, '0, "rd015_after_reset");

        spur_en = 1'b1;
        for (int n = 0; n < 160; n++) begin
            a  = ADDR_W'($urandom_range(0, 63));
            op = int'($urandom_range(0, 7));
            case (op)
                0:       do_access(1'b0, 1'b0, a, $urandom, "rnd_noop");
                1, 2, 3: do_access(1'b1, 1'b0, a, $urandom, "rnd_rd");
                4, 5, 6: do_access(1'b0, 1'b1, a, $urandom, "rnd_wr");
                default: do_access(1'b1, 1'b1, a, $urandom, "rnd_both");
            endcase
        end
        spur_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
